opc_memsys: RTL
===============

OPC_MEMSYS -- requirements
Module: opc_memsys

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data width; MEM_AW, default 20, memory address bits; IO_AW, default 16, IO address bits; MEM_WAIT, default 0 (0..7), memory wait states; IO_WAIT, default 2 (0..7), IO wait states; INT_CHANNELS, default 2 (1..4), interrupt lines; INT_PERIOD, default 16, interrupt-event spacing in clocks; INT_SEED, default 16'hACE1, LFSR seed; IO_CTRL_ADDR, default 'hFE08, interrupt-enable register address.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 address  input  MEM_AW  CPU address.
REQ-005 din  input  DATA_W  write data from CPU.
REQ-006 dout  output  DATA_W  read data to CPU.
REQ-007 rnw  input  1  1 = read, 0 = write.
REQ-008 vpa, vda, vio  input  1 each  program / data / IO access valid.
REQ-009 clken  output  1  CPU clock enable; low = stall.
REQ-010 int_b  output  INT_CHANNELS  active-low interrupt requests.

Function
REQ-011 Space decode SHALL be: vio=1 selects IO; else vpa|vda selects memory; else no access, with vio taking priority when both are set.
REQ-012 Memory SHALL be 2^MEM_AW x DATA_W indexed by address[MEM_AW-1:0]; IO SHALL be 2^IO_AW x DATA_W indexed by address[IO_AW-1:0], with upper bits ignored (wrap).
REQ-013 dout SHALL be a combinational read of the selected array at the current address, and SHALL be 0 when no access is active.
REQ-014 Wait FSM SHALL have states IDLE and WAIT: in IDLE, an access with W>0 (W = MEM_WAIT or IO_WAIT for the decoded space) drives clken=0, loads counter=W-1 and moves to WAIT; in WAIT, clken stays 0, the counter decrements, and at 0 the FSM returns to IDLE with clken=1.
REQ-015 With W=0, clken SHALL stay 1 and the access SHALL complete in the same cycle.
REQ-016 A write (rnw=0) SHALL commit exactly once, on the rising edge ending the cycle in which the access is active and clken=1; reads SHALL have no side effects.
REQ-017 Back-to-back accesses SHALL each incur their full wait count, so an access present in the cycle after completion re-enters WAIT.
REQ-018 Address, rnw or space changes during WAIT SHALL be ignored until completion, and the values present in the completing cycle SHALL be the ones used.
REQ-019 IO address IO_CTRL_ADDR SHALL be the interrupt-enable register (bits [INT_CHANNELS-1:0]): readable, writable, and not stored in the IO array.
REQ-020 The interrupt generator SHALL use a 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps every clock, plus a period counter 0..INT_PERIOD-1.
REQ-021 At period wrap, target channel c = event count mod INT_CHANNELS; if enable[c]=1, int_b[c]=1 and lfsr[6:0] > 85, then int_b[c] SHALL go low for exactly INT_PERIOD cycles, and otherwise int_b[c] SHALL be 1 (deassert).
REQ-022 Clearing enable[c] SHALL force int_b[c]=1 on the next cycle.

Reset
REQ-023 Reset SHALL force FSM=IDLE, counter=0, clken=1, int_b=all ones, enable=0, LFSR=INT_SEED, period counter=0 and event count=0.
REQ-024 Reset asserted mid-WAIT SHALL abort the access with no write committed.
REQ-025 Reset SHALL NOT clear either array contents.

Configuration
REQ-026 With OPC_MEMSYS_INTGEN_EN defined, the interrupt generator (REQ-019..022) SHALL be compiled in.
REQ-027 Without OPC_MEMSYS_INTGEN_EN, int_b SHALL be constant all-ones, no LFSR or counters SHALL exist, and IO_CTRL_ADDR SHALL behave as an ordinary IO location.

Verification
REQ-028 MEM_WAIT=0: write 0xDEADBEEF to 0x00010 with vda=1, then read it back -> clken stays 1 and dout=0xDEADBEEF on the read cycle.
REQ-029 IO_WAIT=2: write 0x41 to IO 0x0100 -> clken low for exactly 2 cycles, IO[0x0100]=0x41 committed once, and a following read returns 0x41 after 2 stall cycles.
REQ-030 vio=1 and vda=1 with address 0x00100 and data 0x55 -> IO[0x0100]=0x55 and memory[0x00100] unchanged.
REQ-031 MEM_WAIT=3: assert reset in the second stall cycle of a write of 0x12345678 -> clken=1 on the next cycle, target location unchanged, and int_b all ones.
REQ-032 OPC_MEMSYS_INTGEN_EN defined: write 0x3 to IO 0xFE08 and run 1000 cycles -> int_b low pulses are each exactly INT_PERIOD cycles, channels alternate per event, and the sequence matches a reference LFSR model seeded 0xACE1.
REQ-033 Address 0xFFFFF with IO_AW=16 and vio=1 -> IO location 0xFFFF is accessed (wrap).

Source files
------------

// File: rtl/opc_memsys.sv
// CPU memory/IO subsystem with wait-state clock-enable stalls and an optional
// LFSR-driven interrupt generator (enabled by defining OPC_MEMSYS_INTGEN_EN).
module opc_memsys #(
    parameter int unsigned     DATA_W       = 32,
    parameter int unsigned     MEM_AW       = 20,
    parameter int unsigned     IO_AW        = 16,
    parameter int unsigned     MEM_WAIT     = 0,
    parameter int unsigned     IO_WAIT      = 2,
    parameter int unsigned     INT_CHANNELS = 2,
    parameter int unsigned     INT_PERIOD   = 16,
    parameter logic [15:0]     INT_SEED     = 16'hACE1,
    parameter logic [IO_AW-1:0] IO_CTRL_ADDR = 'hFE08
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [MEM_AW-1:0]       address,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       dout,
    input  logic                    rnw,
    input  logic                    vpa,
    input  logic                    vda,
    input  logic                    vio,
    output logic                    clken,
    output logic [INT_CHANNELS-1:0] int_b
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   wait_sel;
    logic               access;
    logic               commit;
    logic               is_ctrl;
    logic [DATA_W-1:0]  ctrl_rd;
    logic [IO_AW-1:0]   io_idx;

    logic [DATA_W-1:0]  mem    [2**MEM_AW];
    logic [DATA_W-1:0]  io_mem [2**IO_AW];

    assign access   = vio | vpa | vda;
    assign io_idx   = address[IO_AW-1:0];
    assign wait_sel = vio ? CNT_W'(IO_WAIT) : CNT_W'(MEM_WAIT);
    assign commit   = access && clken && !rnw && !reset;

    // Wait-state sequencer: every access with a non-zero wait count stalls the CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clken     = 1'b1;
        case (state)
            S_IDLE: begin
                if (access && wait_sel != '0) begin
                    clken     = 1'b0;
                    cnt_nxt   = wait_sel - CNT_W'(1);
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    clken   = 1'b0;
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (commit && vio && !is_ctrl) io_mem[io_idx] <= din;
        if (commit && !vio)            mem[address]   <= din;
    end

    always_comb begin
        dout = '0;
        if (vio)              dout = is_ctrl ? ctrl_rd : io_mem[io_idx];
        else if (vpa || vda)  dout = mem[address];
    end

`ifdef OPC_MEMSYS_INTGEN_EN
    localparam int unsigned PER_W = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
    localparam int unsigned CH_W  = (INT_CHANNELS > 1) ? $clog2(INT_CHANNELS) : 1;

    logic [INT_CHANNELS-1:0] enable, enable_nxt, int_q, int_nxt;
    logic [15:0]             lfsr;
    logic [PER_W-1:0]        pcnt;
    logic [CH_W-1:0]         chan;
    logic                    wrap;

    assign is_ctrl    = vio && (io_idx == IO_CTRL_ADDR);
    assign ctrl_rd    = DATA_W'(enable);
    assign enable_nxt = (commit && is_ctrl) ? din[INT_CHANNELS-1:0] : enable;
    assign wrap       = (pcnt == PER_W'(INT_PERIOD - 1));
    assign int_b      = int_q;

    // Every period wrap releases all lines, so a pulse lasts exactly one period.
    always_comb begin
        int_nxt = int_q;
        if (wrap) begin
            int_nxt = '1;
            if (enable[chan] && int_q[chan] && lfsr[6:0] > 7'd85) int_nxt[chan] = 1'b0;
        end
        int_nxt = int_nxt | ~enable_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable <= '0;
            int_q  <= '1;
            lfsr   <= INT_SEED;
            pcnt   <= '0;
            chan   <= '0;
        end else begin
            enable <= enable_nxt;
            int_q  <= int_nxt;
            lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            pcnt   <= wrap ? '0 : pcnt + PER_W'(1);
            if (wrap) chan <= (chan == CH_W'(INT_CHANNELS - 1)) ? '0 : chan + CH_W'(1);
        end
    end
`else
    logic unused_cfg;

    assign is_ctrl    = 1'b0;
    assign ctrl_rd    = '0;
    assign int_b      = '1;
    assign unused_cfg = ^{INT_SEED, IO_CTRL_ADDR, 32'(INT_PERIOD)};
`endif

endmodule
